// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: A - B one bit per clock, LSB first.
// WIDTH+1 edges from operand accept to result valid; result held until out_ready_i.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor cell on the current LSBs plus the running borrow.
  assign d_bit     = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_next   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign res_shift = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sa_d    = a_i;
          sb_d    = b_i;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = br_next;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = res_shift;
          borrow_d = br_next;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == RUN);
  assign out_valid_o = (state_q == DONE);
  assign diff_o      = diff_q;
  assign borrow_o    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle-level behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .diff_o(diff), .borrow_o(borrow), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 computing, 2 result offered.
  int         m_phase = 0;
  int         m_left = 0;
  int         m_pend_d = 0;
  int         m_pend_b = 0;
  int         m_diff = 0;
  int         m_borrow = 0;

  always begin
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_diff = 0; m_borrow = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_pend_d = (int'(a) - int'(b)) & ((1 << WIDTH) - 1);
             m_pend_b = (a < b) ? 1 : 0;
             m_left = WIDTH;
             m_phase = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_phase = 2; m_diff = m_pend_d; m_borrow = m_pend_b;
             end
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
    #2;
    if (chk_en) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("busy", busy, m_phase == 1);
      chk("out_valid", out_valid, m_phase == 2);
      chk("diff", diff, m_diff);
      chk("borrow", borrow, m_borrow);
    end
  end

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ed,
                       input logic eb, input int hold, input bit junk);
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_; out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    if (junk) begin a = 8'hAA; b = 8'h55; end
    else in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (junk) chk("junk_not_accepted", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    chk("latency", n, WIDTH);
    chk("lit_diff", diff, ed);
    chk("lit_borrow", borrow, eb);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_diff", diff, ed);
      chk("hold_in_ready", in_ready, 1'b0);
      if (i == hold - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_out_valid", out_valid, 1'b0);
    chk("post_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_borrow", borrow, 1'b0);

    do_op(8'h05, 8'h03, 8'h02, 1'b0, 0, 1'b0);
    do_op(8'h03, 8'h05, 8'hFE, 1'b1, 0, 1'b0);
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 8'h00, 1'b0, 0, 1'b0);
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 5, 1'b0);
    do_op(8'h10, 8'h01, 8'h0F, 1'b0, 0, 1'b1);

    // Reset sampled on the 4th RUN edge discards the operation.
    @(negedge clk);
    in_valid = 1'b1; a = 8'hFF; b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun_in_ready", in_ready, 1'b1);
    chk("midrun_busy", busy, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midrun_no_valid", out_valid, 1'b0);
    end
    do_op(8'h20, 8'h30, 8'hF0, 1'b1, 0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) != 0);
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = b;
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (WIDTH + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing A − B one bit per clock, LSB first. A single full-subtractor cell and a borrow flip-flop sit behind a valid/ready operand handshake. It is the subtracting counterpart to the full_adder datapath cell. The result is held behind a valid/ready handshake until the consumer accepts it. Used wherever area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is WIDTH ≥ 1.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_n_i  input  1  synchronous active-low reset.
in_valid_i  input  1  operands a_i/b_i are valid.
in_ready_o  output  1  block can accept operands.
a_i  input  WIDTH  minuend.
b_i  input  WIDTH  subtrahend.
out_valid_o  output  1  diff_o/borrow_o are valid.
out_ready_i  input  1  consumer accepts the result.
diff_o  output  WIDTH  (a − b) mod 2^WIDTH.
borrow_o  output  1  1 when a < b (unsigned).
busy_o  output  1  high in RUN.

Behaviour:
- Reset:
  - rst_n_i low at a rising edge forces state IDLE.
  - Clears shift registers, borrow register, bit counter, diff_o and borrow_o to 0.
  - out_valid_o = 0, busy_o = 0, in_ready_o = 1 after that edge.
  - Reset takes priority over every other event, including mid-RUN and DONE; an in-flight operation is discarded with no output.
- FSM states: IDLE, RUN, DONE.
  - in_ready_o = (state == IDLE).
  - busy_o = (state == RUN).
  - out_valid_o = (state == DONE). All three are decoded from registered state.
- IDLE:
  - On an edge with in_valid_i & in_ready_o: latch a_i → sa, b_i → sb, borrow register br ← 0, counter ← 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN (one bit per edge):
  - d = sa[0] ^ sb[0] ^ br.
  - br ← (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - sa and sb shift right by 1.
  - d shifts into the MSB of the result register, which shifts right.
  - counter increments.
  - On the edge processing bit WIDTH−1: go to DONE, load diff_o from the completed result and borrow_o from the final br.
- Latency: operands accepted at edge E0; bits processed at edges E1..E_WIDTH; out_valid_o high after E_WIDTH.
- DONE:
  - diff_o and borrow_o stay stable while out_valid_o = 1.
  - On an edge with out_ready_i = 1: go to IDLE; diff_o and borrow_o keep their values until the next completion.
  - With out_ready_i held high, DONE lasts exactly one cycle.
  - Minimum issue interval is WIDTH + 2 cycles.
- in_valid_i, a_i and b_i are ignored outside IDLE. Changes during RUN/DONE do not affect the in-flight result.
- out_ready_i is ignored outside DONE.
- WIDTH = 1: RUN lasts exactly one edge.
- Arithmetic: diff_o = (a_i − b_i) mod 2^WIDTH; borrow_o = (a_i < b_i) as unsigned values.

Test Plan:
1. WIDTH=8, reset held low 2 cycles then released → in_ready_o=1, out_valid_o=0, busy_o=0, diff_o=0x00, borrow_o=0.
2. a=0x05, b=0x03, out_ready_i=1 → out_valid_o rises 8 edges after acceptance, diff_o=0x02, borrow_o=0, out_valid_o high for one cycle, in_ready_o=1 the cycle after.
3. a=0x03, b=0x05 → diff_o=0xFE, borrow_o=1. Also a=0x00, b=0x01 → diff_o=0xFF, borrow_o=1. Also a=0xFF, b=0xFF → diff_o=0x00, borrow_o=0.
4. Back-pressure: a=0x80, b=0x01, out_ready_i=0 for 5 cycles then 1 → diff_o=0x7F, borrow_o=0 stable all 5 cycles; in_ready_o=0 throughout; returns to IDLE one edge after out_ready_i=1.
5. Busy-ignore: after accepting a=0x10, b=0x01, drive in_valid_i=1 with a=0xAA, b=0x55 during RUN → result diff_o=0x0F, borrow_o=0; the second operand pair is not accepted until in_ready_o=1.
6. Reset mid-RUN: rst_n_i low at the 4th RUN edge → next cycle IDLE, out_valid_o never asserts. A following a=0x20, b=0x30 gives diff_o=0xF0, borrow_o=1 (no stale borrow).
